// File: rtl/input_debouncer_pkg.sv
// Shared constants and state encoding for the input debouncer.
// Encodings are fixed so status/debug logic can decode them.
package input_debouncer_pkg;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      RISING      = 2'd1,
      STABLE_HIGH = 2'd2,
      FALLING     = 2'd3
   } deb_state_t;

   function automatic logic state_level(input deb_state_t s);
      return (s == STABLE_HIGH) || (s == FALLING);
   endfunction

   function automatic logic state_busy(input deb_state_t s);
      return (s == RISING) || (s == FALLING);
   endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for an asynchronous pin.
// Reused for other external inputs.
module synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_low,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] chain = '0;

   always_ff @(posedge clk) begin
      if (!reset_low) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bouncy external input into a clean registered level.
// A new level is accepted after STABLE_CYCLES equal synchronised samples.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter  int SYNC_STAGES   = 2,
   parameter  int STABLE_CYCLES = 16,
   localparam int COUNT_WIDTH   = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic reset_low,
   input  logic raw,
   output logic level,
   output logic busy,
   output logic glitch
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX =
      COUNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
      COUNT_WIDTH'(1);

   logic s;

   deb_state_t             state = STABLE_LOW;
   deb_state_t             state_d;
   logic [COUNT_WIDTH-1:0] cnt = '0;
   logic [COUNT_WIDTH-1:0] cnt_d;
   logic                   glitch_d;

   synchronizer #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset_low(reset_low),
      .async_in (raw),
      .sync_out (s)
   );

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      glitch_d = LOW;
      unique case (state)
         STABLE_LOW: begin
            if (s == HIGH) begin
               state_d = RISING;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         RISING: begin
            if (s == HIGH) begin
               if (cnt == CNT_MAX) begin
                  state_d = STABLE_HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + CNT_ONE;
               end
            end else begin
               state_d  = STABLE_LOW;
               cnt_d    = '0;
               glitch_d = HIGH;
            end
         end
         STABLE_HIGH: begin
            if (s == LOW) begin
               state_d = FALLING;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         FALLING: begin
            if (s == LOW) begin
               if (cnt == CNT_MAX) begin
                  state_d = STABLE_LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + CNT_ONE;
               end
            end else begin
               state_d  = STABLE_HIGH;
               cnt_d    = '0;
               glitch_d = HIGH;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are true flops.
   always_ff @(posedge clk) begin
      if (!reset_low) begin
         state  <= STABLE_LOW;
         cnt    <= '0;
         level  <= LOW;
         busy   <= LOW;
         glitch <= LOW;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         level  <= state_level(state_d);
         busy   <= state_busy(state_d);
         glitch <= glitch_d;
      end
   end

   initial_values_unused : assert property (@(posedge clk) 1'b1);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (STABLE_CYCLES 4 and 2).
// Expected output triples are queued as stimulus is driven.
module tb_input_debouncer;

   logic clk       = 1'b0;
   logic reset_low = 1'b0;
   logic raw       = 1'b0;
   logic raw2      = 1'b0;
   logic level1, busy1, glitch1;
   logic level2, busy2, glitch2;

   logic [5:0] sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   input_debouncer #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4)
   ) dut1 (
      .clk      (clk),
      .reset_low(reset_low),
      .raw      (raw),
      .level    (level1),
      .busy     (busy1),
      .glitch   (glitch1)
   );

   input_debouncer #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(2)
   ) dut2 (
      .clk      (clk),
      .reset_low(reset_low),
      .raw      (raw2),
      .level    (level2),
      .busy     (busy2),
      .glitch   (glitch2)
   );

   function automatic logic [5:0] outs();
      return {level1, busy1, glitch1, level2, busy2, glitch2};
   endfunction

   task automatic test_reset();
      logic [5:0] got, want;
      for (int i = 0; i < 6; i++) begin
         reset_low = (i >= 3);
         raw       = (i < 3);
         raw2      = (i < 3);
         sb.push_back(6'b000_000);
         @(posedge clk); #1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL reset cyc %0d: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_bounce();
      bit [0:7] r  = 8'b11100000;
      bit [0:7] bz = 8'b00111000;
      bit [0:7] gl = 8'b00000100;
      logic [5:0] got, want;
      for (int i = 0; i < 8; i++) begin
         raw = r[i];
         sb.push_back({1'b0, bz[i], gl[i], 3'b000});
         @(posedge clk); #1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL bounce cyc %0d: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_clean_rise();
      bit [0:9] lv = 10'b0000011111;
      bit [0:9] bz = 10'b0011100000;
      logic [5:0] got, want;
      logic prev;
      int rises = 0;
      prev = level1;
      for (int i = 0; i < 10; i++) begin
         raw = 1'b1;
         sb.push_back({lv[i], bz[i], 1'b0, 3'b000});
         @(posedge clk); #1;
         if (level1 && !prev) rises++;
         prev = level1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL rise cyc %0d: got %b want %b", i, got, want);
         end
      end
      n_cmp++;
      if (rises !== 1) begin
         n_bad++;
         $display("FAIL rise pos_edges: got %0d want 1", rises);
      end
   endtask

   task automatic test_clean_fall();
      bit [0:9] lv = 10'b1111100000;
      bit [0:9] bz = 10'b0011100000;
      logic [5:0] got, want;
      logic prev;
      int falls = 0;
      prev = level1;
      for (int i = 0; i < 10; i++) begin
         raw = 1'b0;
         sb.push_back({lv[i], bz[i], 1'b0, 3'b000});
         @(posedge clk); #1;
         if (!level1 && prev) falls++;
         prev = level1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL fall cyc %0d: got %b want %b", i, got, want);
         end
      end
      n_cmp++;
      if (falls !== 1) begin
         n_bad++;
         $display("FAIL fall neg_edges: got %0d want 1", falls);
      end
   endtask

   task automatic test_bouncy_press();
      bit [0:13] r  = 14'b10110111111111;
      bit [0:13] lv = 14'b00000000001111;
      bit [0:13] bz = 14'b00101101110000;
      bit [0:13] gl = 14'b00010010000000;
      logic [5:0] got, want;
      logic prev;
      int rises = 0;
      int glitches = 0;
      prev = level1;
      for (int i = 0; i < 14; i++) begin
         raw = r[i];
         sb.push_back({lv[i], bz[i], gl[i], 3'b000});
         @(posedge clk); #1;
         if (level1 && !prev) rises++;
         if (glitch1) glitches++;
         prev = level1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL press cyc %0d: got %b want %b", i, got, want);
         end
      end
      n_cmp++;
      if (rises !== 1 || glitches !== 2) begin
         n_bad++;
         $display("FAIL press counts: got rises %0d glitches %0d want 1 2",
                  rises, glitches);
      end
   endtask

   task automatic test_reset_mid_settle();
      bit [0:16] rs = 17'b00111111011111111;
      bit [0:16] r  = 17'b00001111111111111;
      bit [0:16] lv = 17'b00000000000000111;
      bit [0:16] bz = 17'b00000011000111000;
      logic [5:0] got, want;
      for (int i = 0; i < 17; i++) begin
         reset_low = rs[i];
         raw       = r[i];
         sb.push_back({lv[i], bz[i], 1'b0, 3'b000});
         @(posedge clk); #1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL rst_mid cyc %0d: got %b want %b", i, got, want);
         end
      end
      reset_low = 1'b1;
   endtask

   task automatic test_stable2();
      bit [0:13] r  = 14'b10000011000000;
      bit [0:13] lv = 14'b00000000011000;
      bit [0:13] bz = 14'b00100000101000;
      bit [0:13] gl = 14'b00010000000000;
      logic [5:0] got, want;
      for (int i = 0; i < 14; i++) begin
         raw2 = r[i];
         sb.push_back({3'b100, lv[i], bz[i], gl[i]});
         @(posedge clk); #1;
         got  = outs();
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL stable2 cyc %0d: got %b want %b", i, got, want);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_bounce();
      test_clean_rise();
      test_clean_fall();
      test_bouncy_press();
      test_reset_mid_settle();
      test_stable2();
      n_cmp++;
      if (sb.size() !== 0) begin
         n_bad++;
         $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
